// File: rtl/scr1_dmem_ahb_pkg.sv
// Shared types, AHB constants and lane helpers for the SCR1 data-memory AHB bridge.
// The helpers operate on 64-bit values; callers truncate to their own DATA_W.
package scr1_dmem_ahb_pkg;

    typedef enum logic [1:0] {
        FSM_ADDR  = 2'b00,
        FSM_DATA  = 2'b01,
        FSM_FLUSH = 2'b10
    } fsm_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE  = 2'b00,
        WIDTH_HWORD = 2'b01,
        WIDTH_WORD  = 2'b10,
        WIDTH_DWORD = 2'b11
    } width_e;

    typedef enum logic {
        MEM_CMD_RD = 1'b0,
        MEM_CMD_WR = 1'b1
    } mem_cmd_e;

    typedef enum logic [1:0] {
        MEM_RESP_NOTRDY = 2'b00,
        MEM_RESP_RDY_OK = 2'b01,
        MEM_RESP_RDY_ER = 2'b10
    } mem_resp_e;

    localparam logic [2:0] HSIZE_8B      = 3'b000;
    localparam logic [2:0] HSIZE_16B     = 3'b001;
    localparam logic [2:0] HSIZE_32B     = 3'b010;
    localparam logic [2:0] HSIZE_64B     = 3'b011;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    // data access, user mode, non-bufferable, non-cacheable
    localparam logic [3:0] HPROT_DATA    = 4'b0001;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    function automatic logic [2:0] width_to_hsize(input width_e width);
        case (width)
            WIDTH_BYTE:  return HSIZE_8B;
            WIDTH_HWORD: return HSIZE_16B;
            WIDTH_WORD:  return HSIZE_32B;
            default:     return HSIZE_64B;
        endcase
    endfunction

    // Replicate the LSB-justified operand across every lane so any byte offset sees it.
    function automatic logic [63:0] wdata_replicate(input width_e width, input logic [63:0] data);
        case (width)
            WIDTH_BYTE:  return {8{data[7:0]}};
            WIDTH_HWORD: return {4{data[15:0]}};
            WIDTH_WORD:  return {2{data[31:0]}};
            default:     return data;
        endcase
    endfunction

    function automatic logic [63:0] rdata_extract(input logic [2:0] hsize, input logic [2:0] offset,
                                                  input logic [63:0] data);
        logic [63:0] shifted;
        shifted = data >> {offset, 3'b000};
        case (hsize)
            HSIZE_8B:  return {56'h0, shifted[7:0]};
            HSIZE_16B: return {48'h0, shifted[15:0]};
            HSIZE_32B: return {32'h0, shifted[31:0]};
            default:   return shifted;
        endcase
    endfunction

endpackage

// File: rtl/scr1_dmem_ahb_pipe_if.sv
// LSU request/response and AHB-Lite master signals of the data-memory bridge.
// master: the bridge side; slave: the core plus AHB fabric around it.
interface scr1_dmem_ahb_pipe_if
    import scr1_dmem_ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              dmem_req_ack;
    logic              dmem_req;
    logic              dmem_cmd;
    logic [1:0]        dmem_width;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    mem_resp_e         dmem_resp;

    logic [3:0]        hprot;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic [1:0]        htrans;
    logic              hmastlock;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;

    modport master (
        output dmem_req_ack, dmem_rdata, dmem_resp,
        output hprot, hburst, hsize, htrans, hmastlock, haddr, hwrite, hwdata,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  hready, hrdata, hresp
    );

    modport slave (
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        input  hprot, hburst, hsize, htrans, hmastlock, haddr, hwrite, hwdata,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output hready, hrdata, hresp
    );

endinterface

// File: rtl/scr1_dmem_ahb_req_fifo.sv
// Generic DEPTH-entry request ring; the head entry is visible combinationally on data_out.
module scr1_dmem_ahb_req_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic [W-1:0] data_out,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A simultaneous pop frees the slot, so a full ring may still take a push.
    assign do_push  = push & (~full | do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/scr1_dmem_ahb_pipe.sv
// SCR1 LSU to AHB-Lite data bridge: request ring, pipelined address/data phases, error flush.
// SCR1_DMEM_AHB_RESP_BYPASS_EN: combinational response path instead of the registered stage.
module scr1_dmem_ahb_pipe
    import scr1_dmem_ahb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REQ_DEPTH = 2
) (
    input logic                   clk,
    input logic                   rst,
    scr1_dmem_ahb_pipe_if.master  bus
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    typedef struct packed {
        logic              hwrite;
        logic [2:0]        hsize;
        logic [ADDR_W-1:0] haddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("scr1_dmem_ahb_pipe: DATA_W must be 32 or 64");
    end

    fsm_e              state_q;
    fsm_e              state_d;
    entry_t            push_entry;
    entry_t            head;
    entry_t            ds_q;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ds_load;
    mem_resp_e         resp_c;
    logic [DATA_W-1:0] rdata_c;

    assign bus.dmem_req_ack = ~full;
    assign push             = bus.dmem_req & ~full;

    always_comb begin
        push_entry.hwrite = bus.dmem_cmd;
        push_entry.hsize  = width_to_hsize(width_e'(bus.dmem_width));
        push_entry.haddr  = bus.dmem_addr;
        push_entry.wdata  = DATA_W'(wdata_replicate(width_e'(bus.dmem_width), 64'(bus.dmem_wdata)));
    end

    scr1_dmem_ahb_req_fifo #(
        .W     (ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .data_in  (push_entry),
        .pop      (pop),
        .data_out (head),
        .full     (full),
        .empty    (empty)
    );

    assign bus.hprot     = HPROT_DATA;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hmastlock = 1'b0;
    assign bus.haddr     = head.haddr;
    assign bus.hwrite    = head.hwrite;
    assign bus.hsize     = head.hsize;
    assign bus.hwdata    = ds_q.wdata;

    // FSM state and data-phase entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FSM_ADDR;
            ds_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ds_load) ds_q <= head;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        ds_load    = 1'b0;
        bus.htrans = HTRANS_IDLE;
        resp_c     = MEM_RESP_NOTRDY;
        rdata_c    = '0;
        case (state_q)
            FSM_ADDR: begin
                if (!empty) begin
                    bus.htrans = HTRANS_NONSEQ;
                    if (bus.hready) begin
                        pop     = 1'b1;
                        ds_load = 1'b1;
                        state_d = FSM_DATA;
                    end
                end
            end
            FSM_DATA: begin
                // Any ERROR cycle withdraws the next address phase.
                if (bus.hresp == HRESP_ERROR) begin
                    if (bus.hready) begin
                        resp_c  = MEM_RESP_RDY_ER;
                        state_d = FSM_FLUSH;
                    end
                end else begin
                    if (!empty) bus.htrans = HTRANS_NONSEQ;
                    if (bus.hready) begin
                        resp_c = MEM_RESP_RDY_OK;
                        if (!ds_q.hwrite) begin
                            rdata_c = DATA_W'(rdata_extract(ds_q.hsize, 3'(ds_q.haddr[OFF_W-1:0]),
                                                            64'(bus.hrdata)));
                        end
                        if (!empty) begin
                            pop     = 1'b1;
                            ds_load = 1'b1;
                        end else begin
                            state_d = FSM_ADDR;
                        end
                    end
                end
            end
            FSM_FLUSH: begin
                if (!empty) begin
                    pop    = 1'b1;
                    resp_c = MEM_RESP_RDY_ER;
                end else if (!push) begin
                    state_d = FSM_ADDR;
                end
            end
            default: state_d = FSM_ADDR;
        endcase
    end

`ifdef SCR1_DMEM_AHB_RESP_BYPASS_EN
    assign bus.dmem_resp  = resp_c;
    assign bus.dmem_rdata = rdata_c;
`else
    mem_resp_e         resp_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q  <= MEM_RESP_NOTRDY;
            rdata_q <= '0;
        end else begin
            resp_q  <= resp_c;
            rdata_q <= rdata_c;
        end
    end

    assign bus.dmem_resp  = resp_q;
    assign bus.dmem_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_scr1_dmem_ahb_pipe.sv
// Directed bench for scr1_dmem_ahb_pipe: a 32-bit/depth-4 and a 64-bit/depth-2 instance.
module tb_scr1_dmem_ahb_pipe;
    import scr1_dmem_ahb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scr1_dmem_ahb_pipe_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
    scr1_dmem_ahb_pipe_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

    scr1_dmem_ahb_pipe #(.ADDR_W(32), .DATA_W(32), .REQ_DEPTH(4)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32.master)
    );

    scr1_dmem_ahb_pipe #(.ADDR_W(32), .DATA_W(64), .REQ_DEPTH(2)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        b32.dmem_req   = 1'b0;
        b32.dmem_cmd   = 1'b0;
        b32.dmem_width = 2'b10;
        b32.dmem_addr  = '0;
        b32.dmem_wdata = '0;
        b32.hready     = 1'b1;
        b32.hresp      = 1'b0;
        b32.hrdata     = '0;
    endtask

    task automatic idle64();
        b64.dmem_req   = 1'b0;
        b64.dmem_cmd   = 1'b0;
        b64.dmem_width = 2'b10;
        b64.dmem_addr  = '0;
        b64.dmem_wdata = '0;
        b64.hready     = 1'b1;
        b64.hresp      = 1'b0;
        b64.hrdata     = '0;
    endtask

    int          acc;
    int          aph;
    int          rsp;
    logic        dvalid;
    logic [31:0] daddr;

    initial begin
        idle32();
        idle64();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        // reset state
        check("rst_htrans",    64'(b32.htrans),       64'(HTRANS_IDLE));
        check("rst_haddr",     64'(b32.haddr),        64'h0);
        check("rst_hwrite",    64'(b32.hwrite),       64'h0);
        check("rst_hsize",     64'(b32.hsize),        64'h0);
        check("rst_hwdata",    64'(b32.hwdata),       64'h0);
        check("rst_rdata",     64'(b32.dmem_rdata),   64'h0);
        check("rst_resp",      64'(b32.dmem_resp),    64'(MEM_RESP_NOTRDY));
        check("rst_ack",       64'(b32.dmem_req_ack), 64'h1);
        check("rst_hburst",    64'(b32.hburst),       64'h0);
        check("rst_hmastlock", 64'(b32.hmastlock),    64'h0);
        check("rst_hprot",     64'(b32.hprot),        64'h1);
        check("rst64_hwdata",  b64.hwdata,            64'h0);
        check("rst64_resp",    64'(b64.dmem_resp),    64'(MEM_RESP_NOTRDY));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // four back-to-back word reads, zero-wait slave
        for (int i = 0; i < 8; i++) begin
            tick();
            b32.dmem_req   = (i < 4);
            b32.dmem_cmd   = 1'b0;
            b32.dmem_width = 2'b10;
            b32.dmem_addr  = 32'h100 + 32'(4 * i);
            b32.hrdata     = 32'hD000_0000 + 32'(i);
            #1;
            check("s1_ack", 64'(b32.dmem_req_ack), 64'h1);
            if (i >= 1 && i <= 4) begin
                check("s1_htrans", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
                check("s1_haddr",  64'(b32.haddr),  64'(32'h100 + 32'(4 * (i - 1))));
            end else begin
                check("s1_htrans_idle", 64'(b32.htrans), 64'(HTRANS_IDLE));
            end
            if (i >= 3 && i <= 6) begin
                check("s1_resp",  64'(b32.dmem_resp),  64'(MEM_RESP_RDY_OK));
                check("s1_rdata", 64'(b32.dmem_rdata), 64'(32'hD000_0000 + 32'(i - 1)));
            end else begin
                check("s1_resp_idle", 64'(b32.dmem_resp), 64'(MEM_RESP_NOTRDY));
            end
        end
        idle32();

        // byte write then byte read at 0x203
        tick();
        b32.dmem_req = 1'b1; b32.dmem_cmd = 1'b1; b32.dmem_width = 2'b00;
        b32.dmem_addr = 32'h203; b32.dmem_wdata = 32'h0000_00A5;
        #1;
        check("s2_ack", 64'(b32.dmem_req_ack), 64'h1);
        tick();
        b32.dmem_cmd = 1'b0; b32.dmem_wdata = '0;
        #1;
        check("s2_wr_htrans", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
        check("s2_wr_haddr",  64'(b32.haddr),  64'h203);
        check("s2_wr_hwrite", 64'(b32.hwrite), 64'h1);
        check("s2_wr_hsize",  64'(b32.hsize),  64'(HSIZE_8B));
        tick();
        b32.dmem_req = 1'b0;
        #1;
        check("s2_hwdata",    64'(b32.hwdata), 64'hA5A5_A5A5);
        check("s2_rd_htrans", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
        check("s2_rd_hwrite", 64'(b32.hwrite), 64'h0);
        check("s2_rd_hsize",  64'(b32.hsize),  64'(HSIZE_8B));
        tick();
        b32.hrdata = 32'h1234_5678;
        #1;
        check("s2_wr_resp", 64'(b32.dmem_resp), 64'(MEM_RESP_RDY_OK));
        tick();
        b32.hrdata = '0;
        #1;
        check("s2_rd_resp",  64'(b32.dmem_resp),  64'(MEM_RESP_RDY_OK));
        check("s2_rd_rdata", 64'(b32.dmem_rdata), 64'h12);
        tick();
        #1;
        check("s2_resp_end", 64'(b32.dmem_resp), 64'(MEM_RESP_NOTRDY));
        idle32();

        // 64-bit path: dword write at 0x08, hword read at 0x0E
        tick();
        b64.dmem_req = 1'b1; b64.dmem_cmd = 1'b1; b64.dmem_width = 2'b11;
        b64.dmem_addr = 32'h08; b64.dmem_wdata = 64'h1122_3344_5566_7788;
        #1;
        check("s3_ack", 64'(b64.dmem_req_ack), 64'h1);
        tick();
        b64.dmem_cmd = 1'b0; b64.dmem_width = 2'b01; b64.dmem_addr = 32'h0E; b64.dmem_wdata = '0;
        #1;
        check("s3_wr_hsize",  64'(b64.hsize),  64'(HSIZE_64B));
        check("s3_wr_hwrite", 64'(b64.hwrite), 64'h1);
        tick();
        b64.dmem_req = 1'b0;
        #1;
        check("s3_hwdata",   b64.hwdata,      64'h1122_3344_5566_7788);
        check("s3_rd_hsize", 64'(b64.hsize),  64'(HSIZE_16B));
        check("s3_rd_haddr", 64'(b64.haddr),  64'h0E);
        tick();
        b64.hrdata = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check("s3_wr_resp", 64'(b64.dmem_resp), 64'(MEM_RESP_RDY_OK));
        tick();
        b64.hrdata = '0;
        #1;
        check("s3_rd_resp",  64'(b64.dmem_resp), 64'(MEM_RESP_RDY_OK));
        check("s3_rd_rdata", b64.dmem_rdata,      64'h0000_0000_0000_AAAA);
        idle64();

        // slave stalls 10 cycles: ring fills, then 9 reads drain in order through wrapping pointers
        acc = 0; aph = 0; rsp = 0; dvalid = 1'b0; daddr = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            b32.dmem_req   = (acc < 9);
            b32.dmem_cmd   = 1'b0;
            b32.dmem_width = 2'b10;
            b32.dmem_addr  = 32'h300 + 32'(4 * acc);
            b32.hready     = (c >= 10);
            b32.hresp      = 1'b0;
            b32.hrdata     = dvalid ? {16'hCAFE, daddr[15:0]} : 32'h0;
            #1;
            if (c == 4 || c == 9) check("s4_ack_full", 64'(b32.dmem_req_ack), 64'h0);
            if (b32.dmem_resp != MEM_RESP_NOTRDY) begin
                check("s4_resp",  64'(b32.dmem_resp),  64'(MEM_RESP_RDY_OK));
                check("s4_rdata", 64'(b32.dmem_rdata), 64'({16'hCAFE, 16'(16'h300 + 16'(4 * rsp))}));
                rsp++;
            end
            if (b32.hready) begin
                if (b32.htrans == HTRANS_NONSEQ) begin
                    check("s4_haddr", 64'(b32.haddr), 64'(32'h300 + 32'(4 * aph)));
                    aph++;
                end
                dvalid = (b32.htrans == HTRANS_NONSEQ);
                daddr  = b32.haddr;
            end
            if (b32.dmem_req && b32.dmem_req_ack) acc++;
            if (c == 9) check("s4_accepts_stalled", 64'(acc), 64'd4);
        end
        check("s4_accepts",   64'(acc), 64'd9);
        check("s4_addrs",     64'(aph), 64'd9);
        check("s4_responses", 64'(rsp), 64'd9);
        idle32();

        // two-cycle ERROR on the first of three queued reads
        for (int c = 0; c < 11; c++) begin
            tick();
            b32.dmem_req  = (c < 3);
            b32.dmem_addr = 32'h400 + 32'(4 * c);
            b32.hready    = !(c < 3 || c == 4);
            b32.hresp     = (c == 4 || c == 5);
            #1;
            if (c >= 4) check("s5_htrans", 64'(b32.htrans), 64'(HTRANS_IDLE));
            if (c >= 6 && c <= 8) check("s5_resp_er", 64'(b32.dmem_resp), 64'(MEM_RESP_RDY_ER));
            else if (c >= 3) check("s5_resp_none", 64'(b32.dmem_resp), 64'(MEM_RESP_NOTRDY));
        end
        idle32();

        // reset in the middle of a data phase with two requests queued
        for (int c = 0; c < 5; c++) begin
            tick();
            b32.dmem_req  = (c < 3);
            b32.dmem_addr = 32'h500 + 32'(4 * c);
            b32.hready    = (c == 3);
            #1;
            if (c == 4) check("s6_pre_htrans", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
        end
        rst = 1'b1;
        #1;
        check("s6_rst_htrans", 64'(b32.htrans),       64'(HTRANS_IDLE));
        check("s6_rst_ack",    64'(b32.dmem_req_ack), 64'h1);
        check("s6_rst_resp",   64'(b32.dmem_resp),    64'(MEM_RESP_NOTRDY));
        check("s6_rst_haddr",  64'(b32.haddr),        64'h0);
        tick();
        rst = 1'b0;
        b32.hready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            check("s6_post_resp",   64'(b32.dmem_resp), 64'(MEM_RESP_NOTRDY));
            check("s6_post_htrans", 64'(b32.htrans),    64'(HTRANS_IDLE));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
